// File: rtl/mips_abb_pkg.sv
// mips_abb_pkg: shared pipeline types, memop encoding and memory-stage FSM states
package mips_abb_pkg;
  typedef logic [31:0] dram_addr;
  typedef logic [31:0] dram_data;
  typedef logic [31:0] reg_word;
  typedef logic [31:0] instr_addr;
  typedef logic [4:0]  reg_addr;
  typedef enum logic [2:0] {MEM_NONE, MEM_B_LOAD, MEM_W_LOAD, MEM_B_STORE, MEM_W_STORE} memop;
  typedef enum logic {IDLE, WAIT} mem_state_e;
  localparam reg_word ZERO = 32'h0000_0000;
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: byte-lane select and sign extension of load data
module mem_load_align
  import mips_abb_pkg::*;
(
  input  memop        op,
  input  logic [1:0]  lane,
  input  dram_data    rdata,
  input  reg_word     res,
  output reg_word     result
);
  logic [7:0] b;
  always_comb begin
    b = rdata[8*lane +: 8];
    result = op == MEM_B_LOAD ? {{24{b[7]}}, b} : op == MEM_W_LOAD ? rdata : res;
  end
endmodule

// File: rtl/stage_mem.sv
// stage_mem: MIPS memory-access stage with dm req/ack handshake and upstream stall.
// Optional MEM_ALIGN_CHECK_EN traps misaligned word accesses.
module stage_mem
  import mips_abb_pkg::*;
#(
  parameter instr_addr RESET_PC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  instr_addr  mem_i_pc,
  input  reg_word    mem_i_res,
  input  logic       mem_i_rfwe,
  input  reg_addr    mem_i_rfwa,
  input  memop       mem_i_memop,
  input  dram_addr   mem_i_mema,
  input  dram_data   mem_i_memd,
  output logic       mem_stall,
  output logic       dm_req,
  output logic       dm_we,
  output logic [3:0] dm_be,
  output dram_addr   dm_addr,
  output dram_data   dm_wdata,
  input  logic       dm_ack,
  input  dram_data   dm_rdata,
  output reg_word    mem_o_res,
  output logic       mem_o_rfwe,
  output reg_addr    mem_o_rfwa,
  output instr_addr  mem_o_pc,
  output logic       mem_o_exc
);
  instr_addr  ex_pc;
  reg_word    ex_res;
  logic       ex_rfwe;
  reg_addr    ex_rfwa;
  memop       ex_memop;
  dram_addr   ex_mema;
  dram_data   ex_memd;
  mem_state_e state;
  logic       misaligned;
  logic       is_store;
  reg_word    result;
`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (ex_memop == MEM_W_LOAD || ex_memop == MEM_W_STORE) && ex_mema[1:0] != 2'b00;
`else
  assign misaligned = 1'b0;
`endif
  assign is_store  = ex_memop == MEM_B_STORE || ex_memop == MEM_W_STORE;
  assign dm_req    = (ex_memop != MEM_NONE && !misaligned) || state == WAIT;
  assign mem_stall = dm_req & ~dm_ack;
  assign dm_we     = dm_req & is_store;
  assign dm_be     = !dm_req ? 4'h0 : ex_memop == MEM_B_STORE ? 4'b0001 << ex_mema[1:0] : 4'hF;
  assign dm_addr   = dm_req ? {ex_mema[31:2], 2'b00} : ZERO;
  assign dm_wdata  = !dm_we ? ZERO : ex_memop == MEM_B_STORE ? {4{ex_memd[7:0]}} : ex_memd;
  mem_load_align u_align (
    .op     (ex_memop),
    .lane   (ex_mema[1:0]),
    .rdata  (dm_rdata),
    .res    (ex_res),
    .result (result)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_pc    <= RESET_PC;
      ex_res   <= ZERO;
      ex_rfwe  <= 1'b0;
      ex_rfwa  <= '0;
      ex_memop <= MEM_NONE;
      ex_mema  <= ZERO;
      ex_memd  <= ZERO;
    end else if (!mem_stall) begin
      ex_pc    <= mem_i_pc;
      ex_res   <= mem_i_res;
      ex_rfwe  <= mem_i_rfwe;
      ex_rfwa  <= mem_i_rfwa;
      ex_memop <= mem_i_memop;
      ex_mema  <= mem_i_mema;
      ex_memd  <= mem_i_memd;
    end
  end
  // in WAIT dm_req is high, so stalling is exactly "still waiting for ack"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= mem_stall ? WAIT : IDLE;
  end
  // a stalled cycle writes a bubble so write-back never commits twice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_o_res  <= ZERO;
      mem_o_rfwe <= 1'b0;
      mem_o_rfwa <= '0;
      mem_o_pc   <= RESET_PC;
    end else begin
      mem_o_res  <= mem_stall ? ZERO : result;
      mem_o_rfwe <= !mem_stall && ex_rfwe && !misaligned;
      mem_o_rfwa <= ex_rfwa;
      mem_o_pc   <= ex_pc;
    end
  end
`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_o_exc <= 1'b0;
    else mem_o_exc <= misaligned;
  end
`else
  assign mem_o_exc = 1'b0;
`endif
endmodule
